// File: rtl/burst_sp_ram_pkg.sv
// Shared types and helpers for the burst single-port RAM.
// The parity helper is used only when BURST_SP_RAM_PARITY_EN is defined.
package burst_sp_ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_RD   = 2'd1,
    OP_WR   = 2'd2
  } op_e;

  localparam int PAR_MAX_BYTES = 64;

  // Even parity per byte: the stored bit makes each 9-bit group have an even count of ones.
  function automatic logic [PAR_MAX_BYTES-1:0] byte_parity(input logic [PAR_MAX_BYTES*8-1:0] d);
    logic [PAR_MAX_BYTES-1:0] p;
    p = '0;
    for (int b = 0; b < PAR_MAX_BYTES; b++) begin
      p[b] = ^d[b*8 +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/burst_sp_ram_if.sv
// Command, write-beat and read-data bundle for burst_sp_ram.
// rd_par_err exists only when BURST_SP_RAM_PARITY_EN is defined.
interface burst_sp_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 8,
  parameter int LEN_WIDTH  = 4
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [AW-1:0]           req_addr;
  logic [LEN_WIDTH-1:0]    req_len;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic                    rd_valid;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_last;
  logic                    busy;
  logic [AW-1:0]           cur_addr;
  logic [1:0]              last_op;
  logic                    wp_err;
`ifdef BURST_SP_RAM_PARITY_EN
  logic [DATA_WIDTH/8-1:0] rd_par_err;
`endif

  modport slave (
    input  req_valid, req_we, req_addr, req_len, wr_valid, wr_data, wr_strb,
    output req_ready, wr_ready, rd_valid, rd_data, rd_last, busy, cur_addr, last_op, wp_err
`ifdef BURST_SP_RAM_PARITY_EN
    , output rd_par_err
`endif
  );

  modport master (
    output req_valid, req_we, req_addr, req_len, wr_valid, wr_data, wr_strb,
    input  req_ready, wr_ready, rd_valid, rd_data, rd_last, busy, cur_addr, last_op, wp_err
`ifdef BURST_SP_RAM_PARITY_EN
    , input rd_par_err
`endif
  );

endinterface

// File: rtl/burst_sp_ram_array.sv
// Byte-strobed word storage with a registered read port; contents are not reset.
// BURST_SP_RAM_PARITY_EN adds one even-parity bit per byte and a per-byte read error flag.
module burst_sp_ram_array
  import burst_sp_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we_i,
  input  logic [DATA_WIDTH/8-1:0]       strb_i,
  input  logic [$clog2(DEPTH)-1:0]      addr_i,
  input  logic [DATA_WIDTH-1:0]         wdata_i,
  input  logic                          re_i,
`ifdef BURST_SP_RAM_PARITY_EN
  output logic [DATA_WIDTH/8-1:0]       par_err_o,
`endif
  output logic [DATA_WIDTH-1:0]         rdata_o
);
  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: INIT_VALUE};
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (strb_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

`ifdef BURST_SP_RAM_PARITY_EN
  localparam logic [NB-1:0] INIT_PAR = NB'(byte_parity((PAR_MAX_BYTES*8)'(INIT_VALUE)));

  logic [NB-1:0] par_q [DEPTH] = '{default: INIT_PAR};
  logic [NB-1:0] par_err_q;
  logic [NB-1:0] wpar;
  logic [NB-1:0] rpar;

  assign wpar = NB'(byte_parity((PAR_MAX_BYTES*8)'(wdata_i)));
  assign rpar = NB'(byte_parity((PAR_MAX_BYTES*8)'(mem_q[addr_i])));

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (strb_i[b]) par_q[addr_i][b] <= wpar[b];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err_q <= '0;
    end else if (re_i) begin
      par_err_q <= rpar ^ par_q[addr_i];
    end
  end

  assign par_err_o = par_err_q;
`endif

endmodule

// File: rtl/burst_sp_ram.sv
// Single-port RAM with incrementing bursts, byte strobes and a write-protected window.
// Optional per-byte parity checking is enabled by defining BURST_SP_RAM_PARITY_EN.
module burst_sp_ram
  import burst_sp_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter int                    LEN_WIDTH  = 4,
  parameter int                    PROT_BASE  = 0,
  parameter int                    PROT_LIMIT = -1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic          clk,
  input  logic          rst,
  burst_sp_ram_if.slave bus_io
);
  localparam int AW = $clog2(DEPTH);

  state_e               state_q;
  logic [AW-1:0]        cur_addr_q;
  logic [AW-1:0]        cur_addr_d;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic [LEN_WIDTH-1:0] cnt_d;
  logic                 req_ready_q;
  logic                 wr_ready_q;
  logic                 busy_q;
  op_e                  last_op_q;
  logic                 wp_err_q;
  logic                 rd_valid_q;
  logic                 rd_last_q;

  logic wr_hs;
  logic prot_hit;
  logic beat_last;
  logic arr_we;
  logic arr_re;

  assign cur_addr_d = cur_addr_q + AW'(1);
  assign cnt_d      = cnt_q - LEN_WIDTH'(1);
  assign beat_last  = (cnt_q == '0);
  assign wr_hs      = (state_q == WR) && bus_io.wr_valid && wr_ready_q;
  // An empty window (PROT_LIMIT < PROT_BASE) makes this permanently false.
  assign prot_hit   = (int'(cur_addr_q) >= PROT_BASE) && (int'(cur_addr_q) <= PROT_LIMIT);
  assign arr_we     = wr_hs && !prot_hit;
  assign arr_re     = (state_q == RD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      last_op_q   <= OP_NONE;
      wp_err_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      // Read data and its flags trail the issue cycle by one clock.
      rd_valid_q <= (state_q == RD);
      rd_last_q  <= (state_q == RD) && beat_last;
      case (state_q)
        IDLE: begin
          if (bus_io.req_valid && req_ready_q) begin
            cur_addr_q  <= bus_io.req_addr;
            cnt_q       <= bus_io.req_len;
            busy_q      <= 1'b1;
            req_ready_q <= 1'b0;
            if (bus_io.req_we) begin
              state_q    <= WR;
              wr_ready_q <= 1'b1;
            end else begin
              state_q <= RD;
            end
          end
        end
        RD: begin
          cur_addr_q <= cur_addr_d;
          if (beat_last) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            last_op_q   <= OP_RD;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WR: begin
          if (wr_hs) begin
            if (prot_hit && (|bus_io.wr_strb)) wp_err_q <= 1'b1;
            cur_addr_q <= cur_addr_d;
            if (beat_last) begin
              state_q     <= IDLE;
              wr_ready_q  <= 1'b0;
              busy_q      <= 1'b0;
              req_ready_q <= 1'b1;
              last_op_q   <= OP_WR;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  burst_sp_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .INIT_VALUE (INIT_VALUE)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .we_i      (arr_we),
    .strb_i    (bus_io.wr_strb),
    .addr_i    (cur_addr_q),
    .wdata_i   (bus_io.wr_data),
    .re_i      (arr_re),
`ifdef BURST_SP_RAM_PARITY_EN
    .par_err_o (bus_io.rd_par_err),
`endif
    .rdata_o   (bus_io.rd_data)
  );

  assign bus_io.req_ready = req_ready_q;
  assign bus_io.wr_ready  = wr_ready_q;
  assign bus_io.rd_valid  = rd_valid_q;
  assign bus_io.rd_last   = rd_last_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.cur_addr  = cur_addr_q;
  assign bus_io.last_op   = last_op_q;
  assign bus_io.wp_err    = wp_err_q;

endmodule

// File: tb/tb_burst_sp_ram.sv
// Directed bench for burst_sp_ram with a protected window at words 16..31.
// Parity checks are compiled in when BURST_SP_RAM_PARITY_EN is defined.
module tb_burst_sp_ram;
  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int LW    = 4;
  localparam int NB    = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  burst_sp_ram_if #(.DATA_WIDTH(DW), .AW(AW), .LEN_WIDTH(LW)) bus ();

  burst_sp_ram #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .LEN_WIDTH  (LW),
    .PROT_BASE  (16),
    .PROT_LIMIT (31),
    .INIT_VALUE ('0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] wd [16];
  logic [NB-1:0] ws [16];
  logic [DW-1:0] ed [16];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Returns at the falling edge right after the accepting rising edge.
  task automatic send_cmd(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] l);
    int t;
    t = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_len   = l;
    while (!bus.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) chk("req_timeout", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input int l, input int stall_beat);
    int t;
    send_cmd(1'b1, a, LW'(l));
    for (int i = 0; i <= l; i++) begin
      if (i == stall_beat) begin
        bus.wr_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
        chk("stall_busy", 64'(bus.busy), 64'd1);
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = wd[i];
      bus.wr_strb  = ws[i];
      t = 0;
      while (!bus.wr_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!bus.wr_ready) chk("wr_timeout", 64'(bus.wr_ready), 64'd1);
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic read_burst(input logic [AW-1:0] a, input int l);
    send_cmd(1'b0, a, LW'(l));
    chk("rd_latency", 64'(bus.rd_valid), 64'd0);
    for (int i = 0; i <= l; i++) begin
      @(negedge clk);
      chk("rd_valid", 64'(bus.rd_valid), 64'd1);
      chk($sformatf("rd_data[%0d]", i), 64'(bus.rd_data), 64'(ed[i]));
      chk($sformatf("rd_last[%0d]", i), 64'(bus.rd_last), 64'(i == l));
    end
    @(negedge clk);
    chk("rd_tail", 64'(bus.rd_valid), 64'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.wr_strb   = '0;
    repeat (3) @(negedge clk);

    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_cur_addr", 64'(bus.cur_addr), 64'd0);
    chk("rst_last_op", 64'(bus.last_op), 64'd0);
    chk("rst_wp_err", 64'(bus.wp_err), 64'd0);
    rst = 1'b0;

    // single-beat write then read
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    write_burst(8'd5, 0, -1);
    chk("wr_last_op", 64'(bus.last_op), 64'd2);
    ed[0] = 32'hDEADBEEF;
    read_burst(8'd5, 0);
    chk("rd_last_op", 64'(bus.last_op), 64'd1);

    // partial strobe merge
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    write_burst(8'd7, 0, -1);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
    write_burst(8'd7, 0, -1);
    ed[0] = 32'h11BB33DD;
    read_burst(8'd7, 0);

    // wrap across DEPTH-1
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'hA0000000 + i; ws[i] = 4'hF; ed[i] = 32'hA0000000 + i;
    end
    write_burst(8'd254, 3, -1);
    read_burst(8'd254, 3);

    // stalled write burst; word 44 must remain untouched
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'hC0DE0000 + i; ws[i] = 4'hF; ed[i] = 32'hC0DE0000 + i;
    end
    ed[4] = 32'h0;
    write_burst(8'd40, 3, 2);
    read_burst(8'd40, 4);

    // protection: zero-strobe beat in window does not flag
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'h0;
    write_burst(8'd20, 0, -1);
    chk("wp_zero_strb", 64'(bus.wp_err), 64'd0);
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'hB0000000 + i; ws[i] = 4'hF;
    end
    write_burst(8'd14, 3, -1);
    chk("wp_set", 64'(bus.wp_err), 64'd1);
    ed[0] = 32'hB0000000; ed[1] = 32'hB0000001; ed[2] = 32'h0; ed[3] = 32'h0;
    read_burst(8'd14, 3);
    // window upper edge: 31 protected, 32 writable
    wd[0] = 32'hE1E1E1E1; wd[1] = 32'hE2E2E2E2; ws[0] = 4'hF; ws[1] = 4'hF;
    write_burst(8'd31, 1, -1);
    ed[0] = 32'h0; ed[1] = 32'hE2E2E2E2;
    read_burst(8'd31, 1);
    chk("wp_sticky", 64'(bus.wp_err), 64'd1);

    // full-length burst (len all ones = 16 beats)
    for (int i = 0; i < 16; i++) begin
      wd[i] = 32'h5A000000 + 32'(i * 3); ws[i] = 4'hF; ed[i] = 32'h5A000000 + 32'(i * 3);
    end
    write_burst(8'd100, 15, -1);
    read_burst(8'd100, 15);

`ifdef BURST_SP_RAM_PARITY_EN
    dut.u_array.par_q[5] = dut.u_array.par_q[5] ^ 4'b0010;
    send_cmd(1'b0, 8'd5, 4'd0);
    @(negedge clk);
    chk("par_err", 64'(bus.rd_par_err), 64'h2);
    @(negedge clk);
`endif

    // reset during beat 2 of an 8-beat read
    send_cmd(1'b0, 8'd0, 4'd7);
    repeat (2) @(negedge clk);
    chk("pre_rst_valid", 64'(bus.rd_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("mid_rst_wp_err", 64'(bus.wp_err), 64'd0);
    chk("mid_rst_last_op", 64'(bus.last_op), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ed[0] = 32'hDEADBEEF;
    read_burst(8'd5, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
